// File: rtl/case_stream_converter.sv
// case_stream_converter
// Streaming ASCII case converter: LANES bytes per beat, one-entry output
// register with valid/ready on both sides (latency 1, full throughput).
// Modes: 00 toggle, 01 upper, 10 lower, 11 title case. word_start_q tracks
// word position across lanes and beats in every mode.
// Optional build macro CASE_STREAM_STATS_EN adds saturating 16-bit
// upper_cnt / lower_cnt letter counters over accepted input beats.
//
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high. in_ready = !out_valid || out_ready, so a held output that is being
// drained this cycle can be replaced in the same edge; valid never depends
// on ready.
module case_stream_converter #(
  parameter int LANES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in,
  input  logic [1:0]         mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out,
  output logic [LANES-1:0]   cap
`ifdef CASE_STREAM_STATS_EN
  ,
  output logic [15:0]        upper_cnt,
  output logic [15:0]        lower_cnt
`endif
);

  logic               out_valid_q;
  logic [8*LANES-1:0] out_q, out_d;
  logic [LANES-1:0]   cap_q, cap_d;
  logic               word_start_q, word_start_d;
  logic               accept;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign cap       = cap_q;

  // Per-lane classification and conversion, word_start chained lane 0 upward.
  always_comb begin
    out_d        = '0;
    cap_d        = '0;
    word_start_d = word_start_q;
    for (int i = 0; i < LANES; i++) begin
      logic [7:0] b;
      logic       is_up;
      logic       is_lo;
      logic       flip;
      b     = in[8*i +: 8];
      is_up = (b >= 8'h41) && (b <= 8'h5A);
      is_lo = (b >= 8'h61) && (b <= 8'h7A);
      unique case (mode)
        2'b00:   flip = is_up || is_lo;
        2'b01:   flip = is_lo;
        2'b10:   flip = is_up;
        default: flip = word_start_d ? is_lo : is_up;
      endcase
      // Only bit 5 ever changes; non-letters never flip.
      out_d[8*i +: 8] = b ^ {2'b00, flip, 5'b00000};
      cap_d[i]        = is_up;
      word_start_d    = !(is_up || is_lo);
    end
  end

  // Output register and word position; untouched when nothing is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      cap_q        <= '0;
      word_start_q <= 1'b1;
    end else if (accept) begin
      out_valid_q  <= 1'b1;
      out_q        <= out_d;
      cap_q        <= cap_d;
      word_start_q <= word_start_d;
    end else if (out_ready) begin
      out_valid_q  <= 1'b0;
    end
  end

`ifdef CASE_STREAM_STATS_EN
  logic [3:0]  up_sum, lo_sum;
  logic [16:0] up_add, lo_add;
  logic [15:0] upper_cnt_q, upper_cnt_d;
  logic [15:0] lower_cnt_q, lower_cnt_d;

  // Letters per beat summed across lanes, then added with saturation.
  always_comb begin
    up_sum = '0;
    lo_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      logic [7:0] b;
      b      = in[8*i +: 8];
      up_sum = up_sum + {3'b000, (b >= 8'h41) && (b <= 8'h5A)};
      lo_sum = lo_sum + {3'b000, (b >= 8'h61) && (b <= 8'h7A)};
    end
    up_add      = {1'b0, upper_cnt_q} + {13'd0, up_sum};
    lo_add      = {1'b0, lower_cnt_q} + {13'd0, lo_sum};
    upper_cnt_d = up_add[16] ? 16'hFFFF : up_add[15:0];
    lower_cnt_d = lo_add[16] ? 16'hFFFF : lo_add[15:0];
  end

  // Counters advance only on accepted beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      upper_cnt_q <= '0;
      lower_cnt_q <= '0;
    end else if (accept) begin
      upper_cnt_q <= upper_cnt_d;
      lower_cnt_q <= lower_cnt_d;
    end
  end

  assign upper_cnt = upper_cnt_q;
  assign lower_cnt = lower_cnt_q;
`endif

endmodule

// File: tb/tb_case_stream_converter.sv
// Bench for case_stream_converter: one LANES=1 and one LANES=4 instance,
// directed vectors with hand-computed results, queue scoreboard on LANES=1.
module tb_case_stream_converter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // LANES=1 instance signals
  logic        v1, r1, rdy1, ov1;
  logic [7:0]  in1, out1;
  logic [1:0]  mode1;
  logic [0:0]  cap1;
  // LANES=4 instance signals
  logic        v4, r4, rdy4, ov4;
  logic [31:0] in4, out4;
  logic [1:0]  mode4;
  logic [3:0]  cap4;
`ifdef CASE_STREAM_STATS_EN
  logic [15:0] up1, lo1, up4, lo4;
`endif

  case_stream_converter #(.LANES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .in(in1),
    .mode(mode1), .out_valid(ov1), .out_ready(r1), .out(out1), .cap(cap1)
`ifdef CASE_STREAM_STATS_EN
    , .upper_cnt(up1), .lower_cnt(lo1)
`endif
  );

  case_stream_converter #(.LANES(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rdy4), .in(in4),
    .mode(mode4), .out_valid(ov4), .out_ready(r4), .out(out4), .cap(cap4)
`ifdef CASE_STREAM_STATS_EN
    , .upper_cnt(up4), .lower_cnt(lo4)
`endif
  );

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard (LANES=1 output stream) ----------------
  logic [8:0] exp_q[$];

  // A transfer completes at the next rising edge whenever valid && ready
  // are seen here, mid-cycle.
  always @(negedge clk) begin
    if (!rst && ov1 && r1) begin
      if (exp_q.size() == 0) check("sb_extra_beat", 1, 0);
      else check("sb_beat", {cap1, out1}, exp_q.pop_front());
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic [1:0] m;
    logic [7:0] i;
    logic [7:0] o;
    logic       c;
  } vec_t;

  // Starting from word_start=1 (after reset).
  vec_t vecs [18] = '{
    '{2'd0, 8'h41, 8'h61, 1'b1}, '{2'd0, 8'h4A, 8'h6A, 1'b1},
    '{2'd0, 8'h64, 8'h44, 1'b0}, '{2'd0, 8'h77, 8'h57, 1'b0},
    '{2'd0, 8'h40, 8'h40, 1'b0}, '{2'd0, 8'h5B, 8'h5B, 1'b0},
    '{2'd0, 8'h60, 8'h60, 1'b0}, '{2'd0, 8'h7B, 8'h7B, 1'b0},
    '{2'd0, 8'hC1, 8'hC1, 1'b0}, '{2'd0, 8'h5A, 8'h7A, 1'b1},
    '{2'd0, 8'h61, 8'h41, 1'b0}, '{2'd0, 8'h7A, 8'h5A, 1'b0},
    '{2'd1, 8'h61, 8'h41, 1'b0}, '{2'd3, 8'h62, 8'h62, 1'b0},
    '{2'd2, 8'h44, 8'h64, 1'b1}, '{2'd3, 8'h20, 8'h20, 1'b0},
    '{2'd3, 8'h63, 8'h43, 1'b0}, '{2'd3, 8'h45, 8'h65, 1'b1}
  };

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    v1 = 0; r1 = 1; in1 = '0; mode1 = '0;
    v4 = 0; r4 = 1; in4 = '0; mode4 = '0;
    step(); step();
    rst = 1'b0;

    // reset state
    check("rst_out_valid1", ov1, 0);
    check("rst_out1", out1, 0);
    check("rst_cap1", cap1, 0);
    check("rst_in_ready1", rdy1, 1);
    check("rst_out_valid4", ov4, 0);
    check("rst_out4", out4, 0);
`ifdef CASE_STREAM_STATS_EN
    check("rst_upper_cnt", up4, 0);
    check("rst_lower_cnt", lo4, 0);
`endif

    // back-to-back vector table, out_ready=1
    r1 = 1;
    foreach (vecs[k]) begin
      mode1 = vecs[k].m;
      in1   = vecs[k].i;
      v1    = 1;
      exp_q.push_back({vecs[k].c, vecs[k].o});
      step();
      check($sformatf("vec%0d_valid", k), ov1, 1);
      check($sformatf("vec%0d_out", k), out1, vecs[k].o);
      check($sformatf("vec%0d_cap", k), cap1, vecs[k].c);
    end
    v1 = 0;
    step();
    check("drain_valid_low", ov1, 0);

    // back-pressure: "a" then "b" in mode 01
    mode1 = 2'd1; r1 = 0; in1 = 8'h61; v1 = 1;
    exp_q.push_back({1'b0, 8'h41});
    exp_q.push_back({1'b0, 8'h42});
    step();
    in1 = 8'h62;
    for (int s = 0; s < 3; s++) begin
      #1;
      check("stall_out", out1, 8'h41);
      check("stall_in_ready", rdy1, 0);
      check("stall_valid", ov1, 1);
      step();
    end
    r1 = 1;
    #1;
    check("release_in_ready", rdy1, 1);
    step();
    check("second_beat_out", out1, 8'h42);
    check("second_beat_valid", ov1, 1);
    v1 = 0;
    step();

    // reset while a beat is held; word position must restart
    mode1 = 2'd0; r1 = 0; in1 = 8'h71; v1 = 1;
    step();
    check("held_before_rst", ov1, 1);
    v1 = 0; rst = 1;
    step();
    rst = 0;
    check("post_rst_valid", ov1, 0);
    check("post_rst_in_ready", rdy1, 1);
    r1 = 1; mode1 = 2'd3; in1 = 8'h78; v1 = 1;
    exp_q.push_back({1'b0, 8'h58});
    step();
    check("post_rst_title_x", out1, 8'h58);
    v1 = 0;
    step();

    // LANES=4 title case across beats, idle gap keeps word position
    mode4 = 2'd3; r4 = 1;
    in4 = 32'h4C4C4568; v4 = 1;            // "hELL"
    step();
    check("l4_b0_out", out4, 32'h6C6C6548); // "Hell"
    check("l4_b0_cap", cap4, 4'b1110);
    in4 = 32'h4F77206F;                      // "o wO"
    step();
    check("l4_b1_out", out4, 32'h6F57206F); // "o Wo"
    check("l4_b1_cap", cap4, 4'b1000);
    v4 = 0;
    step();
    check("l4_gap_valid", ov4, 0);
    check("l4_gap_hold_out", out4, 32'h6F57206F);
    in4 = 32'h21444C52; v4 = 1;            // "RLD!"
    step();
    check("l4_b2_out", out4, 32'h21646C72); // "rld!"
    check("l4_b2_cap", cap4, 4'b0111);
    in4 = 32'h20634261;                      // "aBc "
    step();
    check("l4_b3_out", out4, 32'h20636241); // "Abc "
    mode4 = 2'd0; in4 = 32'h407B7A41;        // "Az{@"
    step();
    check("l4_b4_toggle", out4, 32'h407B5A61);
    check("l4_b4_cap", cap4, 4'b0001);
    v4 = 0;
    step();

`ifdef CASE_STREAM_STATS_EN
    // counters: "AbAb" per beat, 40000 beats saturates both
    rst = 1;
    step();
    rst = 0;
    mode4 = 2'd0; in4 = 32'h62416241; v4 = 1;
    step();
    check("cnt_one_beat_up", up4, 2);
    check("cnt_one_beat_lo", lo4, 2);
    repeat (39999) step();
    v4 = 0;
    step();
    check("cnt_sat_up", up4, 16'hFFFF);
    check("cnt_sat_lo", lo4, 16'hFFFF);
`endif

    check("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
